// File: rtl/move_checker.sv
// Collision/bounds checker for the falling-block game: walks the 20 cells of the five
// candidate placements, one board read per cycle, and publishes all five verdicts at once.
module move_checker #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [19:0] x_move_left,
  input  logic [19:0] y_move_left,
  input  logic [19:0] x_move_right,
  input  logic [19:0] y_move_right,
  input  logic [19:0] x_rotate_right,
  input  logic [19:0] y_rotate_right,
  input  logic [19:0] x_rotate_left,
  input  logic [19:0] y_rotate_left,
  input  logic [19:0] x_move_down,
  input  logic [19:0] y_move_down,
  output logic [4:0]  board_rd_x,
  output logic [4:0]  board_rd_y,
  input  logic        board_rd_occ,
  output logic [4:0]  can_move,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CHECK, DRAIN, PUBLISH} state_t;

  localparam logic [4:0] X_LIM = 5'(BOARD_W);
  localparam logic [4:0] Y_LIM = 5'(BOARD_H);

  state_t            state_r;
  logic [4:0]        idx_r;
  logic [4:0][19:0]  snap_x_r;
  logic [4:0][19:0]  snap_y_r;
  logic [4:0]        work_r;
  logic              pipe_vld_r;
  logic [2:0]        pipe_cand_r;
  logic              addr_inb_r;
  logic [4:0]        rd_x_r;
  logic [4:0]        rd_y_r;
  logic [4:0]        can_move_r;
  logic              busy_r;
  logic              done_r;

  logic [4:0][19:0]  cand_x_s;
  logic [4:0][19:0]  cand_y_s;
  logic [4:0]        nxt_idx_s;
  logic [4:0]        nxt_x_s;
  logic [4:0]        nxt_y_s;
  logic              nxt_sel_s;
  logic              nxt_inb_s;
  logic [4:0]        oob_mask_s;
  logic [4:0]        occ_mask_s;

  // Candidate id 0 (left) sits in the low slot so idx/4 addresses it directly.
  assign cand_x_s = {x_move_down, x_rotate_left, x_rotate_right, x_move_right, x_move_left};
  assign cand_y_s = {y_move_down, y_rotate_left, y_rotate_right, y_move_right, y_move_left};

  function automatic logic [4:0] pick_cell(input logic [4:0][19:0] bus, input logic [4:0] idx);
    logic [19:0] word;
    word = bus[idx[4:2]];
    case (idx[1:0])
      2'd0:    pick_cell = word[19:15];
      2'd1:    pick_cell = word[14:10];
      2'd2:    pick_cell = word[9:5];
      default: pick_cell = word[4:0];
    endcase
  endfunction

  function automatic logic [4:0] cand_bit(input logic [2:0] cand);
    case (cand)
      3'd0:    cand_bit = 5'b10000;
      3'd1:    cand_bit = 5'b01000;
      3'd2:    cand_bit = 5'b00100;
      3'd3:    cand_bit = 5'b00010;
      3'd4:    cand_bit = 5'b00001;
      default: cand_bit = 5'b00000;
    endcase
  endfunction

  // Address for the next cycle; the first read comes straight from the inputs on the start edge.
  always_comb begin
    nxt_idx_s = idx_r + 5'd1;
    nxt_x_s   = 5'd0;
    nxt_y_s   = 5'd0;
    nxt_sel_s = 1'b0;
    if (state_r == IDLE) begin
      nxt_x_s   = pick_cell(cand_x_s, 5'd0);
      nxt_y_s   = pick_cell(cand_y_s, 5'd0);
      nxt_sel_s = start;
    end else if ((state_r == CHECK) && (idx_r != 5'd19)) begin
      nxt_x_s   = pick_cell(snap_x_r, nxt_idx_s);
      nxt_y_s   = pick_cell(snap_y_r, nxt_idx_s);
      nxt_sel_s = 1'b1;
    end else begin
      nxt_sel_s = 1'b0;
    end
    nxt_inb_s = nxt_sel_s && (nxt_x_s < X_LIM) && (nxt_y_s < Y_LIM);
  end

  // Verdict clears: bounds failure for the cell on the bus, occupancy for the one before it.
  always_comb begin
    oob_mask_s = 5'b00000;
    occ_mask_s = 5'b00000;
    if ((state_r == CHECK) && !addr_inb_r) begin
      oob_mask_s = cand_bit(idx_r[4:2]);
    end else begin
      oob_mask_s = 5'b00000;
    end
    if (pipe_vld_r && board_rd_occ) begin
      occ_mask_s = cand_bit(pipe_cand_r);
    end else begin
      occ_mask_s = 5'b00000;
    end
  end

  // Check sequencer with registered read address and published outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r     <= IDLE;
      idx_r       <= 5'd0;
      snap_x_r    <= '0;
      snap_y_r    <= '0;
      work_r      <= 5'b00000;
      pipe_vld_r  <= 1'b0;
      pipe_cand_r <= 3'd0;
      addr_inb_r  <= 1'b0;
      rd_x_r      <= 5'd0;
      rd_y_r      <= 5'd0;
      can_move_r  <= 5'b00000;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      rd_x_r     <= nxt_inb_s ? nxt_x_s : 5'd0;
      rd_y_r     <= nxt_inb_s ? nxt_y_s : 5'd0;
      addr_inb_r <= nxt_inb_s;
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            snap_x_r   <= cand_x_s;
            snap_y_r   <= cand_y_s;
            work_r     <= 5'b11111;
            idx_r      <= 5'd0;
            pipe_vld_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= CHECK;
          end
        end
        CHECK: begin
          work_r      <= work_r & ~oob_mask_s & ~occ_mask_s;
          pipe_vld_r  <= addr_inb_r;
          pipe_cand_r <= idx_r[4:2];
          idx_r       <= nxt_idx_s;
          if (idx_r == 5'd19) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          can_move_r <= work_r & ~occ_mask_s;
          pipe_vld_r <= 1'b0;
          done_r     <= 1'b1;
          busy_r     <= 1'b0;
          state_r    <= PUBLISH;
        end
        PUBLISH: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign board_rd_x = rd_x_r;
  assign board_rd_y = rd_y_r;
  assign can_move   = can_move_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_move_checker.sv
// Self-checking bench for move_checker: directed scenarios plus randomized pieces and boards,
// judged against a cell-by-cell reference of the legality rules.
module tb_move_checker;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        start = 1'b0;
  logic [19:0] x_move_left, y_move_left, x_move_right, y_move_right;
  logic [19:0] x_rotate_right, y_rotate_right, x_rotate_left, y_rotate_left;
  logic [19:0] x_move_down, y_move_down;
  logic [4:0]  board_rd_x, board_rd_y;
  logic        board_rd_occ = 1'b0;
  logic [4:0]  can_move;
  logic        busy, done;

  logic [19:0] cx [5];
  logic [19:0] cy [5];
  logic [19:0] sx [5];
  logic [19:0] sy [5];
  bit          board [0:31][0:31];
  logic [4:0]  prev_can = 5'b00000;
  int          n_checks = 0;
  int          n_pass = 0;

  move_checker #(.BOARD_W(10), .BOARD_H(20)) dut (
    .Clk(Clk), .Reset(Reset), .start(start),
    .x_move_left(x_move_left), .y_move_left(y_move_left),
    .x_move_right(x_move_right), .y_move_right(y_move_right),
    .x_rotate_right(x_rotate_right), .y_rotate_right(y_rotate_right),
    .x_rotate_left(x_rotate_left), .y_rotate_left(y_rotate_left),
    .x_move_down(x_move_down), .y_move_down(y_move_down),
    .board_rd_x(board_rd_x), .board_rd_y(board_rd_y), .board_rd_occ(board_rd_occ),
    .can_move(can_move), .busy(busy), .done(done)
  );

  always #10 Clk = ~Clk;

  // Board store with one cycle of read latency.
  always @(posedge Clk) board_rd_occ <= board[board_rd_x][board_rd_y];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
    return {a[4:0], b[4:0], c[4:0], d[4:0]};
  endfunction

  function automatic int cell_of(input logic [19:0] w, input int k);
    return int'((w >> (5 * k)) & 20'h1f);
  endfunction

  function automatic bit legal(input int c);
    for (int k = 0; k < 4; k++) begin
      int x = cell_of(sx[c], k);
      int y = cell_of(sy[c], k);
      if (x >= 10 || y >= 20) return 1'b0;
      if (board[x][y]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [4:0] model_can();
    logic [4:0] r;
    for (int c = 0; c < 5; c++) r[4-c] = legal(c);
    return r;
  endfunction

  // Expected read address for read number i; out-of-range cells read (0,0).
  function automatic int model_addr(input int i, input bit want_y);
    int x = cell_of(sx[i / 4], 3 - (i % 4));
    int y = cell_of(sy[i / 4], 3 - (i % 4));
    if (x >= 10 || y >= 20) return 0;
    return want_y ? y : x;
  endfunction

  task automatic apply_inputs();
    x_move_left = cx[0];    y_move_left = cy[0];
    x_move_right = cx[1];   y_move_right = cy[1];
    x_rotate_right = cx[2]; y_rotate_right = cy[2];
    x_rotate_left = cx[3];  y_rotate_left = cy[3];
    x_move_down = cx[4];    y_move_down = cy[4];
  endtask

  task automatic clear_board();
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++) board[i][j] = 1'b0;
  endtask

  task automatic base_cands();
    cx[0] = pk(5, 5, 4, 3); cy[0] = pk(0, 1, 1, 1);
    cx[1] = pk(7, 7, 6, 5); cy[1] = pk(0, 1, 1, 1);
    cx[2] = pk(6, 6, 6, 7); cy[2] = pk(0, 1, 2, 2);
    cx[3] = pk(6, 6, 6, 5); cy[3] = pk(0, 1, 2, 0);
    cx[4] = pk(6, 6, 5, 4); cy[4] = pk(1, 2, 2, 2);
  endtask

  // One full check, cycle by cycle. Options: inputs disturbed mid-check, a start offered on
  // the publish edge and held into the next, or reset asserted at cycle rst_at.
  task automatic run_check(input bit pre_started, input bit perturb, input bit b2b, input int rst_at);
    logic [4:0] exp_can;
    if (!pre_started) begin
      @(negedge Clk);
      apply_inputs();
      start = 1'b1;
    end
    sx = cx;
    sy = cy;
    exp_can = model_can();
    @(posedge Clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 23; n++) begin
      @(negedge Clk);
      if (n == rst_at) begin
        Reset = 1'b0;
        #1;
        chk("rst_can", 32'(can_move), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdx", 32'(board_rd_x), 32'd0);
        prev_can = 5'b00000;
        for (int m = 0; m < 3; m++) begin
          @(negedge Clk);
          chk("rst_nodone", 32'(done), 32'd0);
        end
        Reset = 1'b1;
        return;
      end
      if (n <= 20) begin
        chk("rd_x", 32'(board_rd_x), 32'(model_addr(n - 1, 1'b0)));
        chk("rd_y", 32'(board_rd_y), 32'(model_addr(n - 1, 1'b1)));
      end
      chk("busy", 32'(busy), 32'(n <= 21));
      chk("done", 32'(done), 32'(n == 22));
      chk("can_move", 32'(can_move), 32'(n >= 22 ? exp_can : prev_can));
      if (perturb && n == 3) begin
        for (int c = 0; c < 5; c++) begin
          cx[c] = pk(31, 31, 31, 31);
          cy[c] = pk(31, 31, 31, 31);
        end
        apply_inputs();
      end
      if (perturb && n == 10) start = 1'b1;
      if (perturb && n == 11) start = 1'b0;
      if (b2b && n == 22) start = 1'b1;
    end
    prev_can = exp_can;
  endtask

  initial begin
    clear_board();
    base_cands();
    apply_inputs();
    repeat (3) @(negedge Clk);
    chk("reset_can", 32'(can_move), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_rd", 32'({board_rd_x, board_rd_y}), 32'd0);
    Reset = 1'b1;

    // Empty board, every candidate legal.
    run_check(1'b0, 1'b0, 1'b0, 0);
    chk("t_empty", 32'(can_move), 32'h1f);

    // Left wall: left candidate wraps to x=31.
    cx[0] = pk(31, 0, 1, 2); cy[0] = pk(0, 0, 0, 0);
    cx[1] = pk(1, 2, 3, 4);  cy[1] = pk(0, 0, 0, 0);
    cx[2] = pk(1, 1, 1, 1);  cy[2] = pk(0, 1, 2, 3);
    cx[3] = pk(2, 2, 2, 2);  cy[3] = pk(0, 1, 2, 3);
    cx[4] = pk(0, 1, 2, 3);  cy[4] = pk(1, 1, 1, 1);
    run_check(1'b0, 1'b0, 1'b0, 0);
    chk("t_wall", 32'(can_move), 32'h0f);

    // Floor, then floor plus right wall.
    cx[0] = pk(3, 4, 5, 6); cy[0] = pk(19, 19, 19, 19);
    cx[1] = pk(5, 6, 7, 8); cy[1] = pk(19, 19, 19, 19);
    cx[2] = pk(5, 5, 5, 5); cy[2] = pk(16, 17, 18, 19);
    cx[3] = pk(4, 4, 4, 4); cy[3] = pk(16, 17, 18, 19);
    cx[4] = pk(4, 5, 6, 7); cy[4] = pk(20, 20, 20, 20);
    run_check(1'b0, 1'b0, 1'b0, 0);
    chk("t_floor", 32'(can_move), 32'h1e);
    cx[1] = pk(7, 8, 9, 10);
    run_check(1'b0, 1'b0, 1'b0, 0);
    chk("t_floor_wall", 32'(can_move), 32'h16);

    // Occupied (5,2) blocks only the drop, then freed.
    base_cands();
    board[5][2] = 1'b1;
    run_check(1'b0, 1'b0, 1'b0, 0);
    chk("t_occ", 32'(can_move), 32'h1e);
    board[5][2] = 1'b0;
    run_check(1'b0, 1'b0, 1'b0, 0);
    chk("t_occ_clear", 32'(can_move), 32'h1f);

    // Inputs trashed mid-check and a stray start while busy.
    board[5][2] = 1'b1;
    run_check(1'b0, 1'b0, 1'b0, 0);
    board[5][2] = 1'b0;
    base_cands();
    run_check(1'b0, 1'b1, 1'b0, 0);
    chk("t_snapshot", 32'(can_move), 32'h1f);

    // Start on the publish edge is dropped; held one more edge it is taken.
    base_cands();
    board[6][2] = 1'b1;
    run_check(1'b0, 1'b0, 1'b1, 0);
    board[6][2] = 1'b0;
    run_check(1'b1, 1'b0, 1'b0, 0);
    chk("t_b2b", 32'(can_move), 32'h1f);

    // Reset mid-check, then a normal check.
    run_check(1'b0, 1'b0, 1'b0, 10);
    chk("t_rst_hold", 32'(can_move), 32'd0);
    run_check(1'b0, 1'b0, 1'b0, 0);
    chk("t_after_rst", 32'(can_move), 32'h1f);

    // Random pieces and boards, cells occasionally off the edges or wrapped.
    for (int it = 0; it < 40; it++) begin
      clear_board();
      for (int c = 0; c < 5; c++) begin
        int bx = int'($urandom_range(0, 10));
        int by = int'($urandom_range(0, 20));
        int xs [4];
        int ys [4];
        for (int k = 0; k < 4; k++) begin
          xs[k] = (bx + int'($urandom_range(0, 2)) - 1) & 31;
          ys[k] = (by + int'($urandom_range(0, 2)) - 1) & 31;
        end
        cx[c] = pk(xs[3], xs[2], xs[1], xs[0]);
        cy[c] = pk(ys[3], ys[2], ys[1], ys[0]);
      end
      for (int j = 0; j < 3; j++) begin
        int c = int'($urandom_range(0, 4));
        int k = int'($urandom_range(0, 3));
        int x = cell_of(cx[c], k);
        int y = cell_of(cy[c], k);
        if (x < 10 && y < 20 && ($urandom_range(0, 1) == 1)) board[x][y] = 1'b1;
      end
      for (int j = 0; j < 4; j++) board[$urandom_range(0, 9)][$urandom_range(0, 19)] = 1'b1;
      if ($urandom_range(0, 3) == 0) board[0][0] = 1'b1;
      run_check(1'b0, 1'b0, 1'b0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
